// File: rtl/sfifo_pkt.sv
// Single-clock data FIFO with packet commit/abort on the write side; readers only see committed words.
// Optional macro SFIFO_PKT_DROP_EN: a packet that overflowed while open is dropped at its commit.
module sfifo_pkt #(
    parameter int BW        = 8,
    parameter int LGFLEN    = 4,
    parameter int AF_THRESH = (1 << LGFLEN) - 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_commit,
    input  logic              i_abort,
    output logic              o_full,
    output logic              o_afull,
    output logic [LGFLEN:0]   o_fill,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam int FLEN = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN + 1)'(FLEN);
    localparam logic [LGFLEN:0] AF_CNT   = (LGFLEN + 1)'(AF_THRESH);

    logic [BW-1:0]   mem [FLEN];

    logic [LGFLEN:0] wr_addr_q, wr_addr_d;
    logic [LGFLEN:0] cm_addr_q, cm_addr_d;
    logic [LGFLEN:0] rd_addr_q, rd_addr_d;
    logic [LGFLEN:0] sfill_d, fill_d;
    logic [LGFLEN:0] fill_q;
    logic            full_q, afull_q, empty_q, overflow_q, overflow_d;
    logic            w_wr, w_rd, wr_ovf, do_abort, do_commit;

    assign w_wr   = i_wr && !full_q;
    assign w_rd   = i_rd && !empty_q;
    assign wr_ovf = i_wr && full_q;

`ifdef SFIFO_PKT_DROP_EN
    logic pkt_bad_q, pkt_bad_d, pkt_open, pkt_ovf;

    assign pkt_open = (wr_addr_q != cm_addr_q);
    assign pkt_ovf  = wr_ovf && pkt_open;
    // A poisoned packet turns its commit into an abort, including a same-cycle overflow.
    assign do_abort = i_abort || (i_commit && (pkt_bad_q || pkt_ovf));

    always_comb begin
        pkt_bad_d = pkt_bad_q;
        if (do_abort) begin
            pkt_bad_d = 1'b0;
        end else if (pkt_ovf) begin
            pkt_bad_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pkt_bad_q <= 1'b0;
        end else begin
            pkt_bad_q <= pkt_bad_d;
        end
    end
`else
    assign do_abort = i_abort;
`endif

    assign do_commit = i_commit && !do_abort;

    // Flags are derived from next-state pointers so they are exact one cycle after the cause.
    always_comb begin
        wr_addr_d  = wr_addr_q + {{LGFLEN{1'b0}}, w_wr};
        cm_addr_d  = cm_addr_q;
        rd_addr_d  = rd_addr_q + {{LGFLEN{1'b0}}, w_rd};
        overflow_d = overflow_q || wr_ovf;
        if (do_abort) begin
            wr_addr_d = cm_addr_q;
        end else if (do_commit) begin
            cm_addr_d = wr_addr_q + {{LGFLEN{1'b0}}, w_wr};
        end
        sfill_d = wr_addr_d - rd_addr_d;
        fill_d  = cm_addr_d - rd_addr_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_addr_q  <= '0;
            cm_addr_q  <= '0;
            rd_addr_q  <= '0;
            fill_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            cm_addr_q  <= cm_addr_d;
            rd_addr_q  <= rd_addr_d;
            fill_q     <= fill_d;
            empty_q    <= (cm_addr_d == rd_addr_d);
            full_q     <= (sfill_d == FULL_CNT);
            afull_q    <= (sfill_d >= AF_CNT);
            overflow_q <= overflow_d;
        end
    end

    // Aborted words may still land in memory; they are simply unreachable afterwards.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_reset) begin
            mem[wr_addr_q[LGFLEN-1:0]] <= i_data;
        end
    end

    assign o_data     = mem[rd_addr_q[LGFLEN-1:0]];
    assign o_fill     = fill_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_afull    = afull_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_sfifo_pkt.sv
// Table-driven bench for sfifo_pkt: vectors of {inputs, expected outputs} built up front, then applied in order.
// Honours SFIFO_PKT_DROP_EN when the build defines it.
module tb_sfifo_pkt;

    logic       clk = 1'b0;
    logic       reset, wr, commit, abort, rd;
    logic [7:0] din;
    logic       full, afull, empty, overflow;
    logic [4:0] fill;
    logic [7:0] dout;

    always #5 clk = ~clk;

    sfifo_pkt #(.BW(8), .LGFLEN(4), .AF_THRESH(14)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wr       (wr),
        .i_data     (din),
        .i_commit   (commit),
        .i_abort    (abort),
        .o_full     (full),
        .o_afull    (afull),
        .o_fill     (fill),
        .i_rd       (rd),
        .o_data     (dout),
        .o_empty    (empty),
        .o_overflow (overflow)
    );

    typedef struct {
        logic       rst, wr, cm, ab, rd;
        logic [7:0] din;
        logic [4:0] eFill;
        logic       eEmpty, eFull, eAfull, eOvf;
        logic [7:0] eData;
    } vec_t;

    vec_t       vecs[$];
    logic       ovfExp = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] cq[$];
    logic [7:0] pq[$];

    task automatic addVec(input logic rst, input logic w, input logic [7:0] d, input logic cm,
                          input logic ab, input logic r, input int eFill, input logic eFull,
                          input logic eAfull, input logic [7:0] eData);
        vec_t v;
        if (rst) ovfExp = 1'b0;
        v.rst = rst; v.wr = w; v.din = d; v.cm = cm; v.ab = ab; v.rd = r;
        v.eFill = 5'(eFill); v.eEmpty = (eFill == 0); v.eFull = eFull; v.eAfull = eAfull;
        v.eOvf = ovfExp; v.eData = eData;
        vecs.push_back(v);
    endtask

    // Queue reference for the streaming section: cq holds committed words, pq the open packet.
    task automatic modelStep(input logic w, input logic [7:0] d, input logic cm, input logic r);
        int sf;
        if (r && cq.size() > 0) void'(cq.pop_front());
        if (w) pq.push_back(d);
        if (cm) while (pq.size() > 0) cq.push_back(pq.pop_front());
        sf = cq.size() + pq.size();
        addVec(0, w, d, cm, 0, r, cq.size(), sf == 16, sf >= 14, (cq.size() > 0) ? cq[0] : 8'h00);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset = v.rst; wr = v.wr; din = v.din; commit = v.cm; abort = v.ab; rd = v.rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input int idx, input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL vec %0d %s: got %0h expected %0h", idx, name, got, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkOne(idx, "fill", 8'(fill), 8'(v.eFill));
        checkOne(idx, "empty", 8'(empty), 8'(v.eEmpty));
        checkOne(idx, "full", 8'(full), 8'(v.eFull));
        checkOne(idx, "afull", 8'(afull), 8'(v.eAfull));
        checkOne(idx, "overflow", 8'(overflow), 8'(v.eOvf));
        if (!v.eEmpty) checkOne(idx, "data", dout, v.eData);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; din = 8'h00; commit = 1'b0; abort = 1'b0; rd = 1'b0;

        addVec(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        // Speculative writes stay invisible until commit
        addVec(0, 1, 8'h11, 0, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h22, 0, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h33, 0, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 0, 8'h00, 1, 0, 0, 3, 0, 0, 8'h11);
        addVec(0, 0, 8'h00, 0, 0, 1, 2, 0, 0, 8'h22);
        addVec(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h33);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
        // Abort reclaims the open packet, committed data untouched
        addVec(0, 1, 8'hA0, 0, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'hA1, 1, 0, 0, 2, 0, 0, 8'hA0);
        addVec(0, 1, 8'hB0, 0, 0, 0, 2, 0, 0, 8'hA0);
        addVec(0, 1, 8'hB1, 0, 0, 0, 2, 0, 0, 8'hA0);
        addVec(0, 1, 8'hB2, 0, 0, 0, 2, 0, 0, 8'hA0);
        addVec(0, 0, 8'h00, 0, 1, 0, 2, 0, 0, 8'hA0);
        addVec(0, 1, 8'hC0, 1, 0, 0, 3, 0, 0, 8'hA0);
        addVec(0, 0, 8'h00, 0, 0, 1, 2, 0, 0, 8'hA1);
        addVec(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'hC0);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
        // Commit with last write; commit+abort; empty commit/abort
        addVec(0, 1, 8'h5D, 0, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h5E, 1, 0, 0, 2, 0, 0, 8'h5D);
        addVec(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h5E);
        addVec(0, 1, 8'h77, 0, 0, 0, 1, 0, 0, 8'h5E);
        addVec(0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h5E);
        addVec(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h5E);
        addVec(0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h5E);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
        // Fill to full, then one write too many
        for (int k = 0; k < 16; k++)
            addVec(0, 1, 8'(8'h40 + k), 0, 0, 0, 0, k == 15, k >= 13, 8'h00);
        ovfExp = 1'b1;
        addVec(0, 1, 8'hFF, 0, 0, 0, 0, 1, 1, 8'h00);
`ifdef SFIFO_PKT_DROP_EN
        addVec(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h3C, 1, 0, 0, 1, 0, 0, 8'h3C);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);
`else
        addVec(0, 0, 8'h00, 1, 0, 0, 16, 1, 1, 8'h40);
        for (int j = 1; j <= 16; j++)
            addVec(0, 0, 8'h00, 0, 0, 1, 16 - j, 0, (16 - j) >= 14, (j < 16) ? 8'(8'h40 + j) : 8'h00);
`endif
        // Streaming read/write with a commit every third word; pointers wrap
        for (int c = 0; c < 40; c++)
            modelStep(1, 8'(8'h80 + c), (c % 3) == 2, 1);
        for (int c = 0; c < 5; c++)
            modelStep(0, 8'h00, c == 0, 1);
        // Reset mid-packet with committed data present
        for (int k = 0; k < 5; k++)
            addVec(0, 1, 8'(8'hD0 + k), k == 4, 0, 0, (k == 4) ? 5 : 0, 0, 0, (k == 4) ? 8'hD0 : 8'h00);
        addVec(0, 1, 8'hD5, 0, 0, 0, 5, 0, 0, 8'hD0);
        addVec(1, 1, 8'hD6, 1, 0, 1, 0, 0, 0, 8'h00);
        addVec(0, 1, 8'h99, 1, 0, 0, 1, 0, 0, 8'h99);
        addVec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00);

        $display("[TB] applying %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfifo_pkt.md
Name: sfifo_pkt

Overview:
- Synchronous single-clock data FIFO with packet commit/abort on the write side.
- A producer writes a packet speculatively. It then commits the packet, which makes it visible to the reader, or aborts it, which reclaims the space.
- The read side never sees uncommitted data.
- Used between packet parsers (CRC checked at end of frame) and downstream consumers in the bus/debug paths.

Parameters:
- BW, 8, data width in bits.
- LGFLEN, 4, log2 of depth; FLEN=1<<LGFLEN entries.
- AF_THRESH, FLEN-2, o_afull asserts when speculative fill >= AF_THRESH (range 1..FLEN).

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_wr  input  1  write strobe; accepted when !o_full
- i_data  input  BW  write data
- i_commit  input  1  end of packet: commit all speculative writes, including any write accepted this cycle
- i_abort  input  1  discard all uncommitted writes, including any write this cycle
- o_full  output  1  speculative fill == FLEN
- o_afull  output  1  speculative fill >= AF_THRESH
- o_fill  output  LGFLEN+1  committed fill (readable entries)
- i_rd  input  1  read strobe; accepted when !o_empty
- o_data  output  BW  head-of-FIFO data, combinational from mem[rd_addr]
- o_empty  output  1  no committed data
- o_overflow  output  1  sticky: a write arrived while o_full (cleared by reset only)

Behaviour:
- Pointers:
  - wr_addr (speculative), cm_addr (committed) and rd_addr are each LGFLEN+1 bits and wrap modulo 2*FLEN.
  - Memory is indexed by the low LGFLEN bits.
- Fill definitions:
  - Speculative fill sfill = wr_addr - rd_addr; always <= FLEN.
  - Committed fill = cm_addr - rd_addr; always <= sfill.
- Handshakes: w_wr = i_wr && !o_full; w_rd = i_rd && !o_empty.
- Write: w_wr writes mem[wr_addr] and increments wr_addr.
- Commit: i_commit && !i_abort sets cm_addr <= wr_addr + w_wr. The data becomes readable the next cycle.
- Abort:
  - i_abort sets wr_addr <= cm_addr. It wins over i_commit and over a same-cycle w_wr.
  - The memory write may still occur; the data is unreachable.
- Commit/abort with no speculative data are no-ops.
- Read: w_rd increments rd_addr. o_data is valid whenever !o_empty.
- Read on empty is ignored. Write on full is ignored and sets o_overflow.
- Simultaneous w_wr and w_rd: sfill is unchanged.
  - Committed fill changes only by the commit and read terms.
- Flag and count timing: o_fill, o_empty, o_full and o_afull are registered and updated from next-state pointer arithmetic, so all flags are exact in the cycle after the causing event.
  - o_empty = (cm_addr == rd_addr).
  - o_full = (sfill == FLEN).
  - o_afull = (sfill >= AF_THRESH).
- A read that frees a slot clears o_full the next cycle. No same-cycle write-through on full.
- Latency: committed word to !o_empty is 1 cycle after the i_commit edge.
- Reset (synchronous, wins over every other input):
  - All pointers 0.
  - o_empty=1, o_full=0, o_afull=0, o_fill=0, o_overflow=0.
  - A packet in progress is lost.
  - Memory contents are not reset.

Optional Feature:
- Macro: SFIFO_PKT_DROP_EN.
- Defined:
  - An internal sticky pkt_bad is set when a write arrives while o_full during an open packet.
  - The next i_commit is then treated as i_abort: the packet is dropped and pkt_bad clears.
  - o_overflow still sets.
  - i_abort also clears pkt_bad.
- Undefined: no pkt_bad logic.
  - A write on full is merely dropped (partial packet committed on i_commit); o_overflow flags it.

Test Plan (BW=8, LGFLEN=4, AF_THRESH=14):
- Write 0x11,0x22,0x33 without commit -> o_empty stays 1, o_fill=0. Then i_commit -> next cycle o_empty=0, o_fill=3, o_data=0x11; three reads return 0x11,0x22,0x33, then o_empty=1.
- Commit packet {0xA0,0xA1}; write 0xB0,0xB1,0xB2; i_abort -> o_fill=2, sfill back to 2. Write 0xC0 and commit -> reads give 0xA0,0xA1,0xC0.
- Write 16 words with no reads -> o_afull rises after the 14th, o_full after the 16th. A 17th write is ignored and o_overflow=1. Commit -> o_fill=16; one read -> o_full=0 next cycle.
- i_commit together with the last i_wr=0x5E of a packet -> 0x5E included in the commit. i_commit with i_abort asserted together -> abort wins, o_fill unchanged.
- Steady simultaneous read/write across 40 cycles with a commit every 3 words -> pointer wrap past 2*FLEN; data order preserved and o_fill never exceeds 16.
- Assert i_reset mid-packet with o_fill=5 -> next cycle o_empty=1, o_fill=0, o_overflow=0. With SFIFO_PKT_DROP_EN defined: overflowing a packet and then committing -> o_fill unchanged (packet dropped).
